// File: rtl/serial_add_pkg.sv
// serial_add_pkg -- shared definitions for the bit-serial add scheduler.
//
// Contents:
//   state_e        scheduler state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH  default operand / sum width in bits
//   REQ0, REQ1     requester-ID constants as carried on rsp_id
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage : serial_add_pkg

// File: rtl/serial_fa.sv
// serial_fa -- 1-bit full adder with a registered carry, used LSB-first.
//
// Ports:
//   CLK       in   clock, rising edge
//   NRST      in   asynchronous active-low reset (carry -> 0)
//   a, b      in   operand bits for the current cycle
//   load      in   preload the carry register with cin_init
//   cin_init  in   carry-in for the next operation (0 add, 1 subtract)
//   en        in   advance: carry register takes the carry-out of a+b+carry
//   s         out  combinational sum bit of a+b+carry
//   cout      out  registered carry (carry-out of the MSB once done)
module serial_fa (
  input  logic CLK,
  input  logic NRST,
  input  logic a,
  input  logic b,
  input  logic load,
  input  logic cin_init,
  input  logic en,
  output logic s,
  output logic cout
);

  logic carry_q, carry_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    carry_d = carry_q;
    if (load) begin
      carry_d = cin_init;
    end else if (en) begin
      carry_d = (a & b) | (carry_q & (a ^ b));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) carry_q <= 1'b0;
    else       carry_q <= carry_d;
  end

  assign s    = a ^ b ^ carry_q;
  assign cout = carry_q;

endmodule : serial_fa

// File: rtl/serial_add_sched.sv
// serial_add_sched -- round-robin scheduler sharing one bit-serial full adder
// between two requesters.
//
// A granted request is captured into shift registers and added LSB-first over
// WIDTH cycles; the result is returned through a valid/ready response port.
//
// Ports:
//   CLK, NRST                     clock / asynchronous active-low reset
//   reqN_valid, reqN_a, reqN_b    requester N operand pair (N = 0, 1)
//   reqN_sub                      requester N subtract select
//   reqN_ready                    requester N accepted this cycle (IDLE only)
//   rsp_valid, rsp_id             result available / owning requester
//   rsp_sum, rsp_cout             WIDTH-bit result and carry out of the MSB
//   rsp_ready                     consumer takes the result
//
// Build option: SERIAL_ADD_SUB_EN -- when defined, reqN_sub selects
// subtract (b inverted, carry-in 1); otherwise reqN_sub is ignored.
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  input  logic             rsp_ready
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             id_q, id_d;

  logic grant;
  logic fa_b, fa_load, fa_cin, fa_en, fa_s, fa_cout;

`ifdef SERIAL_ADD_SUB_EN
  logic sub_q, sub_d;
`else
  // Subtract inputs are deliberately unused in the add-only build.
  logic unused_sub;
  assign unused_sub = req0_sub | req1_sub;
`endif

  serial_fa u_fa (
    .CLK      (CLK),
    .NRST     (NRST),
    .a        (a_q[0]),
    .b        (fa_b),
    .load     (fa_load),
    .cin_init (fa_cin),
    .en       (fa_en),
    .s        (fa_s),
    .cout     (fa_cout)
  );

  always_comb begin
    // With both requesting, the one not served last wins; otherwise the only
    // valid one (REQ0 is a don't-care default when neither is valid).
    grant = REQ0;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else if (req1_valid)          grant = REQ1;

    req0_ready = (state_q == ST_IDLE) && req0_valid && (grant == REQ0);
    req1_ready = (state_q == ST_IDLE) && req1_valid && (grant == REQ1);

    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    sum_d        = sum_q;
    id_d         = id_q;
    fa_load      = 1'b0;
    fa_cin       = 1'b0;
    fa_en        = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub_d        = sub_q;
    fa_b         = b_q[0] ^ sub_q;
`else
    fa_b         = b_q[0];
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          id_d    = grant;
          cnt_d   = '0;
          fa_load = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
          sub_d   = grant ? req1_sub : req0_sub;
          fa_cin  = sub_d;
`endif
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Operands shift right so bit[cnt] is always at index 0; sum bits
        // enter at the MSB so the first one lands at bit 0 after WIDTH shifts.
        fa_en = 1'b1;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) begin
          last_grant_d = id_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q      <= ST_IDLE;
      last_grant_q <= REQ1;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      id_q         <= REQ0;
`ifdef SERIAL_ADD_SUB_EN
      sub_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sum_q        <= sum_d;
      id_q         <= id_d;
`ifdef SERIAL_ADD_SUB_EN
      sub_q        <= sub_d;
`endif
    end
  end

  // Response fields are gated by DONE so they read zero at all other times,
  // including immediately after an asynchronous reset.
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_id    = rsp_valid & id_q;
  assign rsp_sum   = rsp_valid ? sum_q : '0;
  assign rsp_cout  = rsp_valid & fa_cout;

endmodule : serial_add_sched

// File: doc/serial_add_sched.md
# serial_add_sched

Scheduler that shares one bit-serial full adder between two requesters. It arbitrates round-robin between two operand-pair requests and sequences the shared 1-bit adder LSB-first over WIDTH cycles. It returns the WIDTH-bit sum, the carry-out and the requester ID through a valid/ready response port. It sits in front of the serial adder datapath and is the only block that drives it.

## Interface
- WIDTH, 8, operand/sum width in bits (≥2)
- CLK  in  1  clock, rising edge
- NRST  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_sub  in  1  requester 0 subtract request (see Configuration)
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid, req1_a, req1_b, req1_sub, req1_ready: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_id  out  1  requester the result belongs to
- rsp_sum  out  WIDTH  result
- rsp_cout  out  1  carry out of the MSB
- rsp_ready  in  1  consumer takes the result

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant goes to the only valid requester.
  - If both are valid, grant goes to the requester not served last. The last_grant register resets to 1, so req0 wins first.
  - Only the granted reqN_ready is driven high, combinationally. It is never high outside IDLE.
  - Handshake (valid & ready) captures a, b, sub and id into shift registers, clears bit counter, and moves to RUN.
- RUN:
  - Each cycle presents bit[cnt] of a and b to the adder.
  - The adder carry register is initialised at accept: 0 for add, 1 for subtract.
  - The sum bit is shifted into rsp_sum from the MSB side, so after WIDTH shifts bit 0 sits at LSB.
  - cnt increments each cycle. At cnt == WIDTH-1 the state moves to DONE.
- DONE:
  - rsp_valid = 1. rsp_id, rsp_sum and rsp_cout are held stable until rsp_ready.
  - On rsp_valid & rsp_ready: go to IDLE and update last_grant = rsp_id.
- Arithmetic:
  - rsp_sum = (a + b') mod 2^WIDTH, with b' = b (add) or ~b plus carry-in 1 (subtract).
  - rsp_cout = final carry. For subtract, 1 means no borrow.
- New requests are not accepted while in RUN or DONE. Requesters hold valid and data until ready.
- A requester dropping valid in IDLE before grant is legal and loses nothing.

## Timing
- Reset values: all outputs 0, state IDLE, last_grant 1, cnt 0, carry 0.
- Latency: rsp_valid rises exactly WIDTH cycles after the accept edge.
- Minimum spacing between accepts is WIDTH+2 cycles: WIDTH RUN cycles, 1 DONE cycle with rsp_ready = 1, and 1 IDLE cycle.
- If rsp_ready is already high when DONE is entered, the response completes in that single cycle.
- Reset mid-RUN or mid-DONE aborts the operation immediately. No response is produced and the outputs return to their reset values asynchronously.
- Simultaneous valid from both requesters in IDLE produces exactly one ready.

## Configuration
- SERIAL_ADD_SUB_EN defined: reqN_sub selects subtract (invert b bits, carry-in 1).
- SERIAL_ADD_SUB_EN undefined: the reqN_sub ports exist but are ignored. The operation is always add with carry-in 0, and the invert logic is not built.

## Structure
- Shared package `serial_add_pkg`:
  - state encoding (IDLE/RUN/DONE)
  - default WIDTH
  - requester-ID constants REQ0 = 0, REQ1 = 1
- Sub-module `serial_fa`: 1-bit full adder with carry register.
  - Inputs: a, b, load, cin_init, en.
  - Outputs: s (combinational), cout (registered carry).
  - Instantiated once. The scheduler owns the counter, the shift registers and arbitration.

## Test plan
- WIDTH=8, req0 a=0x35 b=0x4A, rsp_ready=1 -> rsp_valid 8 cycles after accept, sum=0x7F, cout=0, id=0.
- req1 a=0xFF b=0x01 -> sum=0x00, cout=1, id=1.
- Both valid continuously from reset -> ids served 0,1,0,1. Each accept is ≥10 cycles apart. Only one ready is high per grant.
- rsp_ready low for 5 cycles in DONE -> rsp_* stable throughout and both ready outputs stay 0. Raising rsp_ready -> IDLE next cycle.
- NRST pulsed low at RUN cnt=3 -> all outputs 0 immediately and no response. The next req0 0x02+0x03 yields 0x05.
- With SERIAL_ADD_SUB_EN: req1_sub=1 a=0x10 b=0x01 -> 0x0F, cout=1. Without the macro, the same stimulus -> 0x11, cout=0.
